// File: rtl/opcode_assembler_pkg.sv
// Shared opcode geometry and shape codes for the opcode assembler/decoder path.
// Field layout of the 96-bit opcode: shape[95:92], color[91:76], operand data[75:0].
package gpu_pkg;

    localparam int OPCODE_W = 96;
    localparam int SHAPE_W  = 4;
    localparam int COLOR_W  = 16;
    localparam int OPDATA_W = 76;

    localparam int SHAPE_MSB  = OPCODE_W - 1;
    localparam int SHAPE_LSB  = SHAPE_MSB - SHAPE_W + 1;
    localparam int COLOR_MSB  = SHAPE_LSB - 1;
    localparam int COLOR_LSB  = COLOR_MSB - COLOR_W + 1;
    localparam int OPDATA_MSB = COLOR_LSB - 1;
    localparam int OPDATA_LSB = 0;

    typedef logic [OPCODE_W-1:0] opcode_t;

    typedef enum logic [SHAPE_W-1:0] {
        SHAPE_POINT  = 4'd0,
        SHAPE_LINE   = 4'd1,
        SHAPE_TRI    = 4'd2,
        SHAPE_RECT   = 4'd3,
        SHAPE_CIRCLE = 4'd4,
        SHAPE_SPRITE = 4'd5
    } shape_t;

    // Shape codes 0..num_shapes-1 are the only ones the decoder understands.
    function automatic logic shape_is_legal(input logic [SHAPE_W-1:0] shape, input int num_shapes);
        return int'(shape) < num_shapes;
    endfunction

endpackage

// File: rtl/opcode_assembler_if.sv
// Stream bundle between host, opcode assembler and decoder.
// master = host/decoder side, slave = the assembler.
interface opcode_assembler_if #(
    parameter int IN_W       = 32,
    parameter int OPCODE_W   = 96,
    parameter int FIFO_DEPTH = 4
) ();

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [IN_W-1:0]     in_data;
    logic                in_valid;
    logic                in_ready;
    logic                flush;
    logic [OPCODE_W-1:0] opcode;
    logic                op_valid;
    logic                op_ready;
    logic [CNT_W-1:0]    fifo_count;
    logic                bad_op;

    modport master (
        output in_data, in_valid, flush, op_ready,
        input  in_ready, opcode, op_valid, fifo_count, bad_op
    );

    modport slave (
        input  in_data, in_valid, flush, op_ready,
        output in_ready, opcode, op_valid, fifo_count, bad_op
    );

endinterface

// File: rtl/opcode_assembler_fifo.sv
// Synchronous DEPTH x WIDTH opcode FIFO; the head is shown directly from storage.
// Entries are stored verbatim; pushes when full and pops when empty are ignored.
module opcode_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_wr    = i_push & ~o_full;
    assign w_rd    = i_pop & ~o_empty;

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/opcode_assembler.sv
// Packs host words into opcodes (first word in the MS bits) and queues them for the decoder.
// Optional build macro OPCODE_SHAPE_CHECK_EN drops opcodes with an illegal shape and pulses bad_op.
module opcode_assembler #(
    parameter int IN_W       = 32,
    parameter int OPCODE_W   = 96,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_SHAPES = 6
) (
    input  logic               clk,
    input  logic               rst,
    opcode_assembler_if.slave  io_bus
);

    localparam int WORDS = OPCODE_W / IN_W;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int SH_W  = OPCODE_W - IN_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

`ifdef OPCODE_SHAPE_CHECK_EN
    localparam logic SHAPE_CHECK = 1'b1;
`else
    localparam logic SHAPE_CHECK = 1'b0;
`endif

    logic [CNT_W-1:0]            r_word_cnt;
    logic [SH_W-1:0]             r_shreg;
    logic                        r_bad_op;
    logic [OPCODE_W-1:0]         w_assembled;
    logic [gpu_pkg::SHAPE_W-1:0] w_shape;
    logic                        w_last;
    logic                        w_accept;
    logic                        w_complete;
    logic                        w_drop;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_full;
    logic                        w_empty;

    // Only the final word of an opcode can be blocked, and only by a full FIFO as of last edge.
    assign w_last          = (r_word_cnt == LAST_WORD);
    assign io_bus.in_ready = ~(w_last & w_full);
    assign w_accept        = io_bus.in_valid & io_bus.in_ready;

    assign w_assembled = {r_shreg, io_bus.in_data};
    assign w_shape     = w_assembled[OPCODE_W-1 -: gpu_pkg::SHAPE_W];
    assign w_complete  = w_accept & w_last & ~io_bus.flush;
    assign w_drop      = SHAPE_CHECK & ~gpu_pkg::shape_is_legal(w_shape, NUM_SHAPES);
    assign w_push      = w_complete & ~w_drop;
    assign w_pop       = ~w_empty & io_bus.op_ready;

    assign io_bus.op_valid = ~w_empty;
    assign io_bus.bad_op   = r_bad_op;

    // Flush beats a same-cycle accept; the accepted word is simply lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt <= '0;
            r_shreg    <= '0;
            r_bad_op   <= 1'b0;
        end else begin
            r_bad_op <= w_complete & w_drop;
            if (io_bus.flush) begin
                r_word_cnt <= '0;
                r_shreg    <= '0;
            end else if (w_accept) begin
                r_shreg    <= w_assembled[SH_W-1:0];
                r_word_cnt <= w_last ? '0 : r_word_cnt + CNT_W'(1);
            end
        end
    end

    opcode_fifo #(
        .WIDTH (OPCODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_assembled),
        .i_pop   (w_pop),
        .o_rdata (io_bus.opcode),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (io_bus.fifo_count)
    );

endmodule

// File: tb/tb_opcode_assembler.sv
// Directed bench for opcode_assembler: a queue-based model checked every cycle plus literal spot checks.
// Honours OPCODE_SHAPE_CHECK_EN the same way the design does.
module tb_opcode_assembler;

    localparam int IN_W       = 32;
    localparam int OPCODE_W   = 96;
    localparam int DEPTH      = 4;
    localparam int NUM_SHAPES = 6;
    localparam int WORDS      = OPCODE_W / IN_W;

`ifdef OPCODE_SHAPE_CHECK_EN
    localparam bit CHECK_ON = 1'b1;
`else
    localparam bit CHECK_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    opcode_assembler_if #(.IN_W(IN_W), .OPCODE_W(OPCODE_W), .FIFO_DEPTH(DEPTH)) bus ();

    opcode_assembler #(
        .IN_W       (IN_W),
        .OPCODE_W   (OPCODE_W),
        .FIFO_DEPTH (DEPTH),
        .NUM_SHAPES (NUM_SHAPES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: queued opcodes, words collected so far, and last-edge drop flag.
    logic [OPCODE_W-1:0] mq[$];
    logic [IN_W-1:0]     mpart[$];
    bit                  mBad = 1'b0;

    function automatic bit modelReady();
        return !(mpart.size() == WORDS - 1 && mq.size() == DEPTH);
    endfunction

    task automatic checkOutput(input string name, input logic [OPCODE_W-1:0] act, input logic [OPCODE_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model update from the inputs held steady across each rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mpart.delete();
            mBad = 1'b0;
        end else begin
            bit                  acc;
            bit                  pop;
            logic [OPCODE_W-1:0] op;
            acc  = bus.in_valid && modelReady();
            pop  = bus.op_ready && (mq.size() != 0);
            mBad = 1'b0;
            if (pop) void'(mq.pop_front());
            if (bus.flush) begin
                mpart.delete();
            end else if (acc) begin
                if (mpart.size() == WORDS - 1) begin
                    op = {mpart[0], mpart[1], bus.in_data};
                    mpart.delete();
                    if (CHECK_ON && op[95:92] >= NUM_SHAPES) mBad = 1'b1;
                    else mq.push_back(op);
                end else begin
                    mpart.push_back(bus.in_data);
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("opValid", bus.op_valid, (mq.size() != 0));
        checkOutput("fifoCount", bus.fifo_count, mq.size());
        checkOutput("inReady", bus.in_ready, modelReady());
        checkOutput("badOp", bus.bad_op, mBad);
        if (mq.size() != 0) checkOutput("opcode", bus.opcode, mq[0]);
    end

    function automatic logic [IN_W-1:0] wordOf(input int n, input int k);
        return {4'h1, 4'(k), 8'(n), 16'hBEEF};
    endfunction

    function automatic logic [OPCODE_W-1:0] opcodeOf(input int n);
        return {wordOf(n, 0), wordOf(n, 1), wordOf(n, 2)};
    endfunction

    // Offers one word and returns at the falling edge after it was taken.
    task automatic applyStimulus(input logic [IN_W-1:0] w);
        bit done;
        done = 1'b0;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.in_ready) done = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (!done) checkOutput("acceptTimeout", 0, 1);
    endtask

    task automatic sendOpcode(input int n);
        for (int k = 0; k < WORDS; k++) applyStimulus(wordOf(n, k));
    endtask

    task automatic popOne();
        bus.op_ready = 1'b1;
        @(negedge clk);
        bus.op_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, limit 100000 expected less");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.op_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rstOpValid", bus.op_valid, 0);
        checkOutput("rstCount", bus.fifo_count, 0);
        checkOutput("rstOpcode", bus.opcode, 0);
        checkOutput("rstBadOp", bus.bad_op, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstInReady", bus.in_ready, 1);

        // T1: single opcode with the decoder always ready.
        bus.op_ready = 1'b1;
        applyStimulus(32'hA123_4567);
        applyStimulus(32'h89AB_CDEF);
        applyStimulus(32'h0011_2233);
`ifdef OPCODE_SHAPE_CHECK_EN
        checkOutput("t1Dropped", bus.bad_op, 1);
        checkOutput("t1DropValid", bus.op_valid, 0);
`else
        checkOutput("t1Valid", bus.op_valid, 1);
        checkOutput("t1Opcode", bus.opcode, 96'hA1234567_89ABCDEF_00112233);
`endif
        @(negedge clk);
        checkOutput("t1Popped", bus.op_valid, 0);
        bus.op_ready = 1'b0;

        // T2: fill the FIFO, stall the 5th opcode's last word, then release.
        for (int n = 1; n <= 4; n++) sendOpcode(n);
        checkOutput("t2Full", bus.fifo_count, 4);
        applyStimulus(wordOf(5, 0));
        applyStimulus(wordOf(5, 1));
        bus.in_data  = wordOf(5, 2);
        bus.in_valid = 1'b1;
        checkOutput("t2Stall", bus.in_ready, 0);
        @(negedge clk);
        checkOutput("t2StillFull", bus.fifo_count, 4);
        bus.op_ready = 1'b1;
        @(negedge clk);
        checkOutput("t2AfterPop", bus.fifo_count, 3);
        checkOutput("t2Unblocked", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op_ready = 1'b0;
        checkOutput("t2PushPop", bus.fifo_count, 3);
        for (int k = 3; k <= 5; k++) begin
            checkOutput("t2Order", bus.opcode, opcodeOf(k));
            popOne();
        end
        checkOutput("t2Drained", bus.fifo_count, 0);

        // T3: push and pop on the same edge with one entry present.
        sendOpcode(6);
        applyStimulus(wordOf(7, 0));
        applyStimulus(wordOf(7, 1));
        bus.op_ready = 1'b1;
        applyStimulus(wordOf(7, 2));
        bus.op_ready = 1'b0;
        checkOutput("t3Count", bus.fifo_count, 1);
        checkOutput("t3Head", bus.opcode, opcodeOf(7));
        popOne();

        // T4: flush after two words, with a colliding word that must be dropped.
        applyStimulus(32'hDEAD_0001);
        applyStimulus(32'hDEAD_0002);
        bus.flush    = 1'b1;
        bus.in_data  = 32'hDEAD_0003;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("t4FlushCount", bus.fifo_count, 0);
        applyStimulus(32'h2000_0001);
        applyStimulus(32'h2000_0002);
        applyStimulus(32'h2000_0003);
        checkOutput("t4Count", bus.fifo_count, 1);
        checkOutput("t4Head", bus.opcode, 96'h20000001_20000002_20000003);
        popOne();

        // T5: asynchronous reset mid-assembly with two entries queued.
        sendOpcode(8);
        sendOpcode(9);
        applyStimulus(32'h3000_00AA);
        checkOutput("t5Before", bus.fifo_count, 2);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5AsyncValid", bus.op_valid, 0);
        checkOutput("t5AsyncCount", bus.fifo_count, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h3000_0001);
        applyStimulus(32'h3000_0002);
        applyStimulus(32'h3000_0003);
        checkOutput("t5Count", bus.fifo_count, 1);
        checkOutput("t5Head", bus.opcode, 96'h30000001_30000002_30000003);
        popOne();

        // T6: illegal shape code.
        applyStimulus(32'hF000_0001);
        applyStimulus(32'h0000_0002);
        applyStimulus(32'h0000_0003);
`ifdef OPCODE_SHAPE_CHECK_EN
        checkOutput("t6BadPulse", bus.bad_op, 1);
        checkOutput("t6Count", bus.fifo_count, 0);
        @(negedge clk);
        checkOutput("t6BadEnd", bus.bad_op, 0);
`else
        checkOutput("t6NoBad", bus.bad_op, 0);
        checkOutput("t6Count", bus.fifo_count, 1);
        checkOutput("t6Head", bus.opcode, 96'hF0000001_00000002_00000003);
        popOne();
`endif
        sendOpcode(10);
        checkOutput("t6WrapCount", bus.fifo_count, 1);
        checkOutput("t6WrapHead", bus.opcode, opcodeOf(10));
        popOne();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
